// File: rtl/alu_seq_driver.sv
// alu_seq_driver: BIST sequencer driving a 4-bit ALU and folding results into a MISR; ALU_SEQ_EXHAUSTIVE_EN selects all 256 operand pairs
module alu_seq_driver #(
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] SIG_SEED      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [1:0]  alu_sel,
  input  logic [7:0]  alu_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [10:0] result_cnt
);
`ifdef ALU_SEQ_EXHAUSTIVE_EN
  localparam int IW = 10;
`else
  localparam int IW = 3;
`endif
  localparam logic [IW-1:0] LAST  = '1;
  localparam logic [3:0]    SLAST = 4'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t state, nxt;
  logic [3:0] scnt, va, vb;
  logic [IW-1:0] idx, vidx;
  logic load;
  logic [15:0] misr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = (start && !abort) ? DRIVE : IDLE;
      DRIVE:   nxt = abort ? IDLE : (scnt == SLAST) ? SAMPLE : DRIVE;
      SAMPLE:  nxt = abort ? IDLE : (idx == LAST) ? DONE : DRIVE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = (state == DRIVE) || (state == SAMPLE);
    done = (state == DONE);
  end
  assign load = (nxt == DRIVE) && (state != DRIVE);
  assign vidx = (state == IDLE) ? '0 : idx + 1'b1;
`ifdef ALU_SEQ_EXHAUSTIVE_EN
  assign va = vidx[9:6];
  assign vb = vidx[5:2];
`else
  assign va = vidx[2] ? 4'h6 : 4'h0;
  assign vb = vidx[2] ? 4'hA : 4'hF;
`endif
  assign misr = {signature[14:0], signature[15] ^ signature[13] ^ signature[12] ^ signature[10]} ^ {8'h00, alu_out};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      idx        <= '0;
      scnt       <= '0;
      signature  <= SIG_SEED;
      result_cnt <= '0;
    end else begin
      if (load) begin
        alu_a   <= va;
        alu_b   <= vb;
        alu_sel <= vidx[1:0];
        idx     <= vidx;
        scnt    <= '0;
      end else if (state == DRIVE) scnt <= scnt + 4'd1;
      if (state == IDLE && nxt == DRIVE) begin
        signature  <= SIG_SEED;
        result_cnt <= '0;
      end else if (state == SAMPLE && !abort) begin
        signature  <= misr;
        result_cnt <= result_cnt + 11'd1;
      end
    end
endmodule

// File: tb/tb_alu_seq_driver.sv
// tb_alu_seq_driver: vector-table and scoreboard bench for alu_seq_driver with a stand-in ALU
module tb_alu_seq_driver;
`ifdef ALU_SEQ_EXHAUSTIVE_EN
  localparam int NV = 1024;
  localparam int SETTLE = 2;
`else
  localparam int NV = 8;
  localparam int SETTLE = 1;
`endif
  localparam logic [15:0] SEED = 16'h1234;
  localparam int RUN = NV * (SETTLE + 1) + 1;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [3:0] alu_a, alu_b, a0, b0;
  logic [1:0] alu_sel, s0;
  logic [7:0] alu_out;
  logic busy, done, busy0, done0;
  logic [15:0] signature, sig0;
  logic [10:0] result_cnt, cnt0;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [3:0] a, b; logic [1:0] sel;} vec_t;
  vec_t tbl[NV];
  vec_t q[$];
  vec_t e;
  always #5 clk = ~clk;
  function automatic logic [7:0] alu_f(logic [3:0] a, logic [3:0] b, logic [1:0] s);
    return s == 2'd0 ? {4'h0, a} + {4'h0, b} : s == 2'd1 ? {a, b} : s == 2'd2 ? 8'(a) * 8'(b) : {a ^ b, a & b};
  endfunction
  function automatic logic [15:0] misr(logic [15:0] s, logic [7:0] d);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {8'h00, d};
  endfunction
  assign alu_out = alu_f(alu_a, alu_b, alu_sel);
  alu_seq_driver #(.SETTLE_CYCLES(SETTLE), .SIG_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .busy(busy), .done(done), .signature(signature), .result_cnt(result_cnt));
  alu_seq_driver #(.SETTLE_CYCLES(SETTLE), .SIG_SEED(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .alu_a(a0), .alu_b(b0), .alu_sel(s0), .alu_out(8'h01),
    .busy(busy0), .done(done0), .signature(sig0), .result_cnt(cnt0));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  int held = 0, popped = 0;
  bit prev_busy = 0, hold_chk = 1;
  logic [9:0] prev_v = '0;
  always @(negedge clk) begin
    if (busy && (!prev_busy || {alu_a, alu_b, alu_sel} != prev_v)) begin
      if (prev_busy && hold_chk) chk("hold", held, SETTLE + 1);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_extra: got vector %0h expected none", {alu_a, alu_b, alu_sel});
      end else begin
        e = q.pop_front();
        chk("vec", {alu_a, alu_b, alu_sel}, {e.a, e.b, e.sel});
        popped++;
      end
      held = 1;
    end else if (busy) held++;
    else if (prev_busy && hold_chk) chk("hold_last", held, SETTLE + 1);
    prev_busy = busy;
    prev_v = {alu_a, alu_b, alu_sel};
  end
  task automatic run(input int abort_at, input int rep_at, input int rst_at,
                     output int done_k, output int ndone, output int end_k);
    bit fin = 0;
    q.delete();
    popped = 0;
    foreach (tbl[i]) q.push_back(tbl[i]);
    start = 1;
    done_k = -1;
    ndone = 0;
    end_k = 0;
    for (int k = 1; k <= RUN + 20; k++) begin
      @(negedge clk);
      start = (k == rep_at);
      abort = (k == abort_at);
      end_k = k;
      if (done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (k == rst_at) begin
        rst_n = 0;
        #1;
        chk("busy_async_rst", busy, 0);
        fin = 1;
        break;
      end
      if (!busy && !done) begin
        fin = 1;
        break;
      end
    end
    start = 0;
    abort = 0;
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_timeout: got busy after %0d cycles expected idle", RUN + 20);
    end
  endtask
  initial begin
    int dk, nd, ek;
    logic [15:0] exp_sig, exp0, part;
    for (int i = 0; i < NV; i++) begin
      logic [9:0] v;
      v = 10'(i);
`ifdef ALU_SEQ_EXHAUSTIVE_EN
      tbl[i] = '{v[9:6], v[5:2], v[1:0]};
`else
      tbl[i] = '{v[2] ? 4'h6 : 4'h0, v[2] ? 4'hA : 4'hF, v[1:0]};
`endif
    end
    exp_sig = SEED;
    exp0 = 16'h0000;
    part = SEED;
    foreach (tbl[i]) begin
      exp_sig = misr(exp_sig, alu_f(tbl[i].a, tbl[i].b, tbl[i].sel));
      exp0 = misr(exp0, 8'h01);
      if (i < 2) part = misr(part, alu_f(tbl[i].a, tbl[i].b, tbl[i].sel));
    end
    repeat (2) @(negedge clk);
    chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_sig", signature, 16'h1234);
    chk("rst_sig0", sig0, 16'h0000);
    chk("rst_cnt", result_cnt, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    run(0, RUN, 0, dk, nd, ek);
    chk("done_cycle", dk, RUN);
    chk("done_pulses", nd, 1);
    chk("end_cycle", ek, RUN + 1);
    chk("vec_count", popped, NV);
    chk("cnt", result_cnt, NV);
    chk("sig", signature, exp_sig);
    chk("sig0", sig0, exp0);
`ifndef ALU_SEQ_EXHAUSTIVE_EN
    chk("sig0_lit", sig0, 16'h00FF);
`endif
    chk("alu_hold_last", {alu_a, alu_b, alu_sel}, {tbl[NV-1].a, tbl[NV-1].b, tbl[NV-1].sel});
    @(negedge clk);
    chk("start_in_done_ignored", {busy, done}, 0);
    run(3 * (SETTLE + 1), 0, 0, dk, nd, ek);
    chk("abort_end", ek, 3 * (SETTLE + 1) + 1);
    chk("abort_no_done", nd, 0);
    chk("abort_cnt", result_cnt, 2);
    chk("abort_vecs", popped, 3);
    chk("abort_sig", signature, part);
    repeat (2) @(negedge clk);
    chk("abort_sig_held", signature, part);
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    chk("abort_beats_start", busy, 0);
    chk("abort_start_cnt", result_cnt, 2);
    run(0, 5, 0, dk, nd, ek);
    chk("repulse_done_cycle", dk, RUN);
    chk("repulse_pulses", nd, 1);
    chk("repulse_cnt", result_cnt, NV);
    chk("repulse_sig", signature, exp_sig);
    hold_chk = 0;
    run(0, 0, 8, dk, nd, ek);
    chk("rst_mid_done", {done, nd[0]}, 0);
    chk("rst_mid_sig", signature, SEED);
    chk("rst_mid_cnt", result_cnt, 0);
    chk("rst_mid_alu", {alu_a, alu_b, alu_sel}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    hold_chk = 1;
    run(0, 0, 0, dk, nd, ek);
    chk("rerun_done_cycle", dk, RUN);
    chk("rerun_sig", signature, exp_sig);
    chk("rerun_cnt0", cnt0, NV);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
